// File: rtl/countdown_mmss.sv
// countdown_mmss: three-digit BCD M:SS countdown timer.
// Keypad digits shift in from the right while stopped. The time counts
// down once per synchronized 1 Hz tick while running. A one-cycle done
// pulse marks expiry.
module countdown_mmss #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       load,
    input  logic [3:0] digit,
    input  logic       pgt_1hz,
    input  logic       run,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {SETUP, COUNT, EXPIRED} state_t;

    state_t     state, state_next;
    logic [3:0] mins_next, tens_next, ones_next;
    logic       done_next;

    logic [SYNC_STAGES-1:0] load_sync, tick_sync;
    logic                   load_prev, tick_prev;
    logic [3:0]             digit_pipe [SYNC_STAGES];

    logic       load_p, tick_p;
    logic [3:0] digit_d;
    logic [3:0] dec_mins, dec_tens, dec_ones;
    logic       dec_zero;

    // Synchronize load/pgt_1hz; flops reset high so a level held through reset is no edge
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            load_sync <= '1;
            tick_sync <= '1;
            load_prev <= 1'b1;
            tick_prev <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                digit_pipe[i] <= 4'd0;
            end
        end else begin
            load_sync     <= {load_sync[SYNC_STAGES-2:0], load};
            tick_sync     <= {tick_sync[SYNC_STAGES-2:0], pgt_1hz};
            load_prev     <= load_sync[SYNC_STAGES-1];
            tick_prev     <= tick_sync[SYNC_STAGES-1];
            digit_pipe[0] <= digit;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                digit_pipe[i] <= digit_pipe[i-1];
            end
        end
    end

    assign load_p  = load_sync[SYNC_STAGES-1] & ~load_prev;
    assign tick_p  = tick_sync[SYNC_STAGES-1] & ~tick_prev;
    assign digit_d = digit_pipe[SYNC_STAGES-1];

    assign zero = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign busy = (state == COUNT);

    // One-second BCD decrement with borrow; unnormalized tens digits count down as-is
    always_comb begin
        dec_mins = mins;
        dec_tens = sec_tens;
        dec_ones = sec_ones;
        if (sec_ones != 4'd0) begin
            dec_ones = sec_ones - 4'd1;
        end else begin
            dec_ones = 4'd9;
            if (sec_tens != 4'd0) begin
                dec_tens = sec_tens - 4'd1;
            end else begin
                dec_tens = 4'd5;
                dec_mins = mins - 4'd1;
            end
        end
    end

    assign dec_zero = (dec_mins == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

    // Next state, digit updates and expiry pulse
    always_comb begin
        state_next = state;
        mins_next  = mins;
        tens_next  = sec_tens;
        ones_next  = sec_ones;
        done_next  = 1'b0;
        case (state)
            SETUP: begin
                if (load_p && (digit_d <= 4'd9)) begin
                    mins_next = sec_tens;
                    tens_next = sec_ones;
                    ones_next = digit_d;
                end
                if (run && !zero) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (tick_p) begin
                    mins_next = dec_mins;
                    tens_next = dec_tens;
                    ones_next = dec_ones;
                end
                if (tick_p && dec_zero) begin
                    state_next = EXPIRED;
                    done_next  = 1'b1;
                end else if (!run) begin
                    state_next = SETUP;
                end
            end
            EXPIRED: begin
                if (!run) begin
                    state_next = SETUP;
                end
            end
            default: begin
                state_next = SETUP;
            end
        endcase
    end

    // State, digit and done registers
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state    <= SETUP;
            mins     <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            mins     <= mins_next;
            sec_tens <= tens_next;
            sec_ones <= ones_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_countdown_mmss.sv
// Testbench for countdown_mmss: a decimal-number model of the M:SS time,
// checked against the DUT every cycle, plus literal spot checks.
module tb_countdown_mmss;

    localparam int S = 2;

    logic       clk;
    logic       clearn;
    logic       load;
    logic [3:0] digit;
    logic       pgt_1hz;
    logic       run;
    logic [3:0] mins, sec_tens, sec_ones;
    logic       zero, busy, done;

    int total;
    int bad;
    int done_cnt;
    int done_before;

    // Model: time held as a decimal number mm*100 + tens*10 + ones
    int mv;
    int mstate;
    int mdone;
    int cyc;
    int prev_l, prev_p;
    int ldue[$];
    int ldig[$];
    int tdue[$];
    int lev, tev, dval, old;

    countdown_mmss #(.SYNC_STAGES(S)) dut (
        .clk(clk),
        .clearn(clearn),
        .load(load),
        .digit(digit),
        .pgt_1hz(pgt_1hz),
        .run(run),
        .mins(mins),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .zero(zero),
        .busy(busy),
        .done(done)
    );

    // 50 MHz-style free-running clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: input rises take effect S edges after they are first sampled
    always @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            mv = 0;
            mstate = 0;
            mdone = 0;
            cyc = 0;
            prev_l = 1;
            prev_p = 1;
            ldue.delete();
            ldig.delete();
            tdue.delete();
        end else begin
            cyc++;
            lev = 0;
            tev = 0;
            dval = 0;
            if (ldue.size() > 0 && ldue[0] == cyc) begin
                lev = 1;
                dval = ldig[0];
                void'(ldue.pop_front());
                void'(ldig.pop_front());
            end
            if (tdue.size() > 0 && tdue[0] == cyc) begin
                tev = 1;
                void'(tdue.pop_front());
            end
            mdone = 0;
            old = mv;
            case (mstate)
                0: begin
                    if (lev == 1 && dval <= 9) mv = (mv % 100) * 10 + dval;
                    if (run && old != 0) mstate = 1;
                end
                1: begin
                    if (tev == 1) mv = (mv % 100 == 0) ? mv - 41 : mv - 1;
                    if (tev == 1 && mv == 0) begin
                        mstate = 2;
                        mdone = 1;
                    end else if (!run) begin
                        mstate = 0;
                    end
                end
                default: begin
                    if (!run) mstate = 0;
                end
            endcase
            if (load && prev_l == 0) begin
                ldue.push_back(cyc + S);
                ldig.push_back(int'(digit));
            end
            if (pgt_1hz && prev_p == 0) tdue.push_back(cyc + S);
            prev_l = int'(load);
            prev_p = int'(pgt_1hz);
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (clearn) begin
            checkOutput("mins", int'(mins), mv / 100);
            checkOutput("sec_tens", int'(sec_tens), (mv / 10) % 10);
            checkOutput("sec_ones", int'(sec_ones), mv % 10);
            checkOutput("zero", int'(zero), (mv == 0) ? 1 : 0);
            checkOutput("busy", int'(busy), (mstate == 1) ? 1 : 0);
            checkOutput("done", int'(done), mdone);
            if (done) done_cnt++;
        end
    end

    task automatic applyStimulus(input logic l, input logic [3:0] d, input logic p,
                                 input logic r, input int n);
        load = l;
        digit = d;
        pgt_1hz = p;
        run = r;
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        applyStimulus(1'b1, d, pgt_1hz, run, 10);
        applyStimulus(1'b0, d, pgt_1hz, run, 10);
    endtask

    task automatic tick();
        applyStimulus(load, digit, 1'b1, run, 4);
        applyStimulus(load, digit, 1'b0, run, 4);
    endtask

    task automatic checkTime(input string name, input int m, input int t, input int o);
        checkOutput({name, "_m"}, int'(mins), m);
        checkOutput({name, "_t"}, int'(sec_tens), t);
        checkOutput({name, "_o"}, int'(sec_ones), o);
    endtask

    initial begin
        total = 0;
        bad = 0;
        done_cnt = 0;
        clearn = 1'b0;
        load = 1'b1;
        digit = 4'd5;
        pgt_1hz = 1'b0;
        run = 1'b0;
        repeat (3) @(negedge clk);

        // Release reset with load already high: no shift
        clearn = 1'b1;
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 6);
        checkTime("rst_hold", 0, 0, 0);
        checkOutput("rst_zero", int'(zero), 1);
        checkOutput("rst_busy", int'(busy), 0);
        applyStimulus(1'b0, 4'd5, 1'b0, 1'b0, 6);

        // Key 1 with explicit latency check, then 12 (ignored), 3, 12, 0
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 2);
        checkOutput("lat_before", int'(sec_ones), 0);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1);
        checkOutput("lat_at3", int'(sec_ones), 1);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 7);
        applyStimulus(1'b0, 4'd1, 1'b0, 1'b0, 10);
        press(4'd12);
        checkTime("key12", 0, 0, 1);
        press(4'd3);
        press(4'd12);
        press(4'd0);
        checkTime("keys130", 1, 3, 0);

        // 1:00 -> 0:59 -> ... -> 0:00 with one done pulse
        press(4'd1);
        press(4'd0);
        press(4'd0);
        checkTime("load100", 1, 0, 0);
        run = 1'b1;
        done_before = done_cnt;
        tick();
        checkTime("first_tick", 0, 5, 9);
        checkOutput("busy_count", int'(busy), 1);
        for (int i = 0; i < 59; i++) tick();
        checkTime("expired", 0, 0, 0);
        checkOutput("busy_exp", int'(busy), 0);
        checkOutput("done_pulses_100", done_cnt - done_before, 1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4);

        // Unnormalized 0:90 counts through 0:89 ... 0:00
        press(4'd0);
        press(4'd9);
        press(4'd0);
        checkTime("load090", 0, 9, 0);
        run = 1'b1;
        done_before = done_cnt;
        tick();
        checkTime("t089", 0, 8, 9);
        for (int i = 0; i < 90; i++) tick();
        checkTime("exp090", 0, 0, 0);
        checkOutput("done_pulses_090", done_cnt - done_before, 1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4);

        // 2:05, three ticks, pause and edit, then loads during COUNT ignored
        press(4'd2);
        press(4'd0);
        press(4'd5);
        run = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checkTime("t202", 2, 0, 2);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 3);
        press(4'd7);
        checkTime("edit027", 0, 2, 7);
        run = 1'b1;
        press(4'd4);
        press(4'd8);
        checkTime("cnt_load_ign", 0, 2, 7);
        checkOutput("busy_027", int'(busy), 1);

        // Async reset mid-count at 1:11
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 3);
        press(4'd1);
        press(4'd1);
        press(4'd1);
        checkTime("load111", 1, 1, 1);
        run = 1'b1;
        done_before = done_cnt;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 clearn = 1'b0;
        #1;
        checkTime("async_rst", 0, 0, 0);
        checkOutput("async_done", int'(done), 0);
        checkOutput("async_busy", int'(busy), 0);
        @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        clearn = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 10);
        checkOutput("no_done_rst", done_cnt - done_before, 0);
        checkTime("after_rst", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
